srff_driver: RTL and testbench
==============================

Name: srff_driver

Overview:
- Command-side driver for a bank of clocked SR flip-flops; the producing end of the s/r interface that the flip-flop cells consume.
- Accepts masked write requests (target bit values) over a valid/ready handshake.
- Derives per-bit set/reset excitation from flip-flop feedback and drives timed s/r pulses.
- After a settle window, verifies the feedback matches the target and records per-bit errors.

Parameters:
- WIDTH, 8: number of flip-flop channels driven.
- PULSE_CYCLES, 2: cycles s/r are held asserted; must be >= 1.
- SETTLE_CYCLES, 2: wait cycles between pulse end and check; 0 allowed (SETTLE skipped).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  driver can accept a request.
- req_data  input  WIDTH  target value per bit.
- req_mask  input  WIDTH  1 = bit is written; 0 = bit is held.
- q_fb  input  WIDTH  q outputs of the driven flip-flops.
- s  output  WIDTH  set commands to the flip-flops.
- r  output  WIDTH  reset commands to the flip-flops.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky; high when any err_bits bit is set.
- err_bits  output  WIDTH  sticky per-bit mismatch flags.
- err_clr  input  1  synchronous clear of err and err_bits.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; s=r=0; busy=0; done=0; err=0; err_bits=0. req_ready=0 while rst is high and 1 in the first cycle after release. Reset during PULSE drops s/r immediately, without waiting for a clock edge.
- All outputs are registered.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready. req_ready=1 only in IDLE.
  - req_data/req_mask/q_fb are sampled only on the accept edge.
  - The requester must hold req_valid/req_data/req_mask stable until the request is accepted.
- Excitation computed on the accept edge (SR excitation table):
  - set_v = mask & data & ~q_fb.
  - rst_v = mask & ~data & q_fb.
  - exp = (q_fb & ~mask) | (data & mask).
  - Bits already at target, or unmasked bits, get s=r=0.
  - s & r is never 1 on the same bit in any cycle; this is an invariant.
- States:
  - IDLE: on accept, go to PULSE if (set_v|rst_v)!=0, otherwise go to CHECK (no-op request).
  - PULSE: s=set_v, r=rst_v for exactly PULSE_CYCLES cycles, starting the cycle after the accept edge. Then go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
  - SETTLE: s=r=0 for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK: one cycle. At its ending edge:
    - err_bits |= (q_fb ^ exp);
    - return to IDLE;
    - done=1 for that following cycle, with req_ready=1 in the same cycle.
- Latency: done asserts PULSE_CYCLES+SETTLE_CYCLES+1 cycles after the accept edge; a no-op request gives 1. The next request can be accepted on the edge that ends the done cycle, giving back-to-back throughput with no bubble beyond done.
- Counter: a single down-counter of width clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1), reloaded on each state entry.
- Errors:
  - err = |err_bits.
  - err_clr clears err_bits in any state.
  - If err_clr coincides with a CHECK edge, the result is exactly the new mismatch bits (new errors win).
  - Errors never block operation.
- Unmasked bits are compared too. A spurious change on a held bit is flagged.
- req_valid while busy is ignored; the request is not lost if req_valid is held.

Test Plan:
- Bench setup: WIDTH=8, PULSE_CYCLES=2, SETTLE_CYCLES=2. A behavioural SR flip-flop bank is clocked on clk, s/r feed it, and its q drives q_fb. Each scenario checks that s&r is never 1 on the same bit.
- Reset then set: after reset q_fb=0x00. Request data=0xA5, mask=0xFF → s=0xA5, r=0x00 for exactly 2 cycles; done 5 cycles after accept; q_fb=0xA5; err=0.
- Masked reset: q_fb=0xFF, request data=0x00, mask=0x0F → r=0x0F, s=0x00 for 2 cycles; final q_fb=0xF0; err_bits=0x00.
- No-op request: q_fb=0x3C, request data=0x3C, mask=0xFF → s=r=0 throughout; done 1 cycle after accept; busy high for 1 cycle.
- Fault injection: force model bit 2 stuck at 0, request data=0x04, mask=0x04 → err_bits=0x04, err=1. Next, err_clr pulse → err_bits=0x00. Then err_clr coinciding with a new failing CHECK → err_bits=0x04.
- Reset mid-pulse: assert rst one cycle into PULSE → s=r=0 immediately (asynchronous, before the next edge); busy=0; no done pulse; req_ready=1 after release.
- Back-to-back requests: hold req_valid with data 0x01 then 0x02 (mask=0xFF) → second accept on the edge ending the first done; req_ready low for exactly the busy span; two done pulses; final q_fb=0x02.

Source files
------------

// File: rtl/srff_driver.sv
// Command-side driver for a bank of clocked SR flip-flops: accepts masked
// write requests, drives timed s/r pulses, then verifies feedback against the target.
module srff_driver #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    input  logic             err_clr
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp_q;

    logic             accept;
    logic [WIDTH-1:0] set_v;
    logic [WIDTH-1:0] rst_v;
    logic [WIDTH-1:0] exp_v;
    logic [WIDTH-1:0] err_next;

    // Excitation from the SR table: set and reset terms are disjoint by construction,
    // so s & r can never be high together on a bit.
    assign set_v = req_mask & req_data & ~q_fb;
    assign rst_v = req_mask & ~req_data & q_fb;
    assign exp_v = (q_fb & ~req_mask) | (req_data & req_mask);

    assign accept = req_valid & req_ready;

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        err_next = err_clr ? '0 : err_bits;
        if (state == CHECK) begin
            err_next = err_next | (q_fb ^ exp_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    // The async reset also drops s/r mid-pulse without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            exp_q     <= '0;
            s         <= '0;
            r         <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_bits  <= '0;
            err       <= 1'b0;
        end else begin
            done     <= 1'b0;
            err_bits <= err_next;
            err      <= |err_next;

            case (state)
                IDLE: begin
                    if (accept) begin
                        exp_q     <= exp_v;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if ((set_v | rst_v) != '0) begin
                            state <= PULSE;
                            s     <= set_v;
                            r     <= rst_v;
                            cnt   <= PULSE_LOAD;
                        end else begin
                            state <= CHECK;
                            cnt   <= '0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                PULSE: begin
                    if (cnt == '0) begin
                        s <= '0;
                        r <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            state <= CHECK;
                            cnt   <= '0;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CHECK: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    s         <= '0;
                    r         <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srff_driver.sv
// Self-checking bench for srff_driver: behavioural SR flip-flop bank on s/r,
// vector table plus hand-written sequences, scoreboard checked on each done pulse.
module tb_srff_driver;

    localparam int W   = 8;
    localparam int P   = 2;
    localparam int S   = 2;
    localparam int LAT = P + S + 1;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_data  = '0;
    logic [W-1:0] req_mask  = '0;
    logic [W-1:0] q_fb;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] err_bits;
    logic         err_clr   = 1'b0;

    srff_driver #(
        .WIDTH        (W),
        .PULSE_CYCLES (P),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_mask (req_mask),
        .q_fb     (q_fb),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_bits (err_bits),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Behavioural SR flip-flop bank with preload and stuck-at-0 fault injection.
    logic         load_en  = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] stuck    = '0;
    logic [W-1:0] q_m      = '0;

    always @(posedge clk) begin
        if (load_en) q_m <= load_val & ~stuck;
        else         q_m <= ((q_m | s) & ~r) & ~stuck;
    end
    assign q_fb = q_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_eb;
        int           exp_lat;
        int           exp_pulses;
        time          t_acc;
    } sb_t;

    sb_t sb[$];

    int  pulse_n  = 0;
    int  busy_n   = 0;
    int  sr_bad   = 0;
    int  overlap  = 0;
    int  rb_viol  = 0;
    int  dw_viol  = 0;
    int  done_cnt = 0;
    logic done_d  = 1'b0;
    time last_done_t = 0;

    // Output monitor: invariants every cycle, scoreboard comparison on each done.
    always @(negedge clk) begin : mon
        sb_t e;
        if (rst) begin
            pulse_n = 0;
            busy_n  = 0;
            sr_bad  = 0;
            done_d  = 1'b0;
        end else begin
            if ((s & r) != '0) overlap++;
            if (req_ready !== ~busy) rb_viol++;
            if (done && done_d) dw_viol++;
            done_d = done;
            if (busy) busy_n++;
            if ((s | r) != '0) begin
                pulse_n++;
                if (sb.size() == 0 || s !== sb[0].exp_s || r !== sb[0].exp_r) sr_bad++;
            end
            if (done) begin
                done_cnt++;
                last_done_t = $time;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("err_bits", 32'(err_bits), 32'(e.exp_eb));
                    check("err", 32'(err), 32'(|e.exp_eb));
                    check("q_final", 32'(q_m), 32'(e.exp_q));
                    check("latency", 32'(($time - e.t_acc - 5) / 10), 32'(e.exp_lat));
                    check("pulse_cycles", 32'(pulse_n), 32'(e.exp_pulses));
                    check("busy_cycles", 32'(busy_n), 32'(e.exp_lat));
                    check("sr_pattern", 32'(sr_bad), 0);
                end
                pulse_n = 0;
                busy_n  = 0;
                sr_bad  = 0;
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic issue(input logic [W-1:0] d, input logic [W-1:0] m,
                         input logic [W-1:0] es, input logic [W-1:0] er,
                         input logic [W-1:0] eq, input logic [W-1:0] eb,
                         input int lat, input int pul, input bit push, output time t_acc);
        sb_t e;
        t_acc     = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_mask  = m;
        for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
        check("accept_ready", 32'(req_ready), 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        if (push) begin
            e = '{es, er, eq, eb, lat, pul, t_acc};
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    task automatic load_q(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] pre;
        logic [W-1:0] stk;
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_eb;
        int           exp_lat;
        int           exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        time t2;
        int  dc;

        //          pre    stuck  data   mask   s      r      q      err_bits lat  pulses
        vecs[0] = '{8'h00, 8'h00, 8'hA5, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h00, LAT, P};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'hF0, 8'h00, LAT, P};
        vecs[2] = '{8'h3C, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h00, 1,   0};
        vecs[3] = '{8'h0F, 8'h00, 8'hF0, 8'hFF, 8'hF0, 8'h0F, 8'hF0, 8'h00, LAT, P};
        vecs[4] = '{8'h55, 8'h00, 8'hAA, 8'h3C, 8'h28, 8'h14, 8'h69, 8'h00, LAT, P};
        vecs[5] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04, LAT, P};

        // Reset state, asynchronously applied before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_s", 32'(s), 0);
        check("rst_r", 32'(r), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_bits", 32'(err_bits), 0);
        check("rst_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 1);
        check("busy_after_release", 32'(busy), 0);

        foreach (vecs[k]) begin
            stuck = vecs[k].stk;
            load_q(vecs[k].pre);
            issue(vecs[k].data, vecs[k].mask, vecs[k].exp_s, vecs[k].exp_r,
                  vecs[k].exp_q, vecs[k].exp_eb, vecs[k].exp_lat, vecs[k].exp_pulses, 1'b1, t1);
            req_valid = 1'b0;
            drain();
        end

        // Standalone err_clr pulse.
        stuck   = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err_bits", 32'(err_bits), 0);
        check("clr_err", 32'(err), 0);

        // New failure on bit 5, then err_clr coinciding with a failing CHECK on bit 2.
        stuck = 8'h20;
        load_q(8'h00);
        issue(8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h20, LAT, P, 1'b1, t1);
        req_valid = 1'b0;
        drain();
        stuck = 8'h04;
        load_q(8'h00);
        issue(8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04, LAT, P, 1'b1, t1);
        req_valid = 1'b0;
        repeat (P + S) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        drain();
        stuck = '0;

        // Reset one cycle into PULSE drops s/r before the next edge.
        load_q(8'h00);
        issue(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, LAT, P, 1'b0, t1);
        req_valid = 1'b0;
        check("mid_pulse_s_before_rst", 32'(s), 32'hFF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_s", 32'(s), 0);
        check("rst_mid_r", 32'(r), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ready", 32'(req_ready), 0);
        check("rst_mid_err_bits", 32'(err_bits), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        dc = done_cnt;
        @(negedge clk);
        check("rst_mid_ready_after", 32'(req_ready), 1);
        repeat (8) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - dc), 0);

        // Back-to-back requests with req_valid held throughout.
        load_q(8'h00);
        issue(8'h01, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00, LAT, P, 1'b1, t1);
        dc = done_cnt;
        issue(8'h02, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h00, LAT, P, 1'b1, t2);
        req_valid = 1'b0;
        check("b2b_accept_gap", 32'((t2 - t1) / 10), 32'(LAT + 1));
        check("b2b_accept_after_done", 32'(t2 - last_done_t), 5);
        drain();
        check("b2b_done_pulses", 32'(done_cnt - dc), 2);
        check("b2b_q_final", 32'(q_m), 32'h02);

        check("sr_exclusive", 32'(overlap), 0);
        check("ready_vs_busy", 32'(rb_viol), 0);
        check("done_width", 32'(dw_viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
